// File: rtl/mc6502_mux_defs.sv
// mc6502_mux_defs: shared state encodings and sizing constants for the CPU datapath selector/demux pair
package mc6502_mux_defs;
  localparam int N_DEST = 8;
  localparam int SEL_W = 3;
  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;
endpackage

// File: rtl/dec3to8.sv
// dec3to8: combinational 3-to-8 one-hot decoder (sel -> onehot)
module dec3to8
  import mc6502_mux_defs::*;
(
  input  logic [SEL_W-1:0]  sel,
  output logic [N_DEST-1:0] onehot
);
  assign onehot = N_DEST'(1) << sel;
endmodule

// File: rtl/demux8_wr.sv
// demux8_wr: valid/ready write demux into eight held registers with per-destination strobe/ack and read-back (CLK, RES_N, VALID/READY, SEL, D, Y0..Y7, STB, ACK, RD_SEL, RD_Y; DEMUX8_WR_AUTOACK_EN makes STB a one-cycle pulse)
module demux8_wr
  import mc6502_mux_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RES_N,
  input  logic              VALID,
  output logic              READY,
  input  logic [SEL_W-1:0]  SEL,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Y0,
  output logic [WIDTH-1:0]  Y1,
  output logic [WIDTH-1:0]  Y2,
  output logic [WIDTH-1:0]  Y3,
  output logic [WIDTH-1:0]  Y4,
  output logic [WIDTH-1:0]  Y5,
  output logic [WIDTH-1:0]  Y6,
  output logic [WIDTH-1:0]  Y7,
  output logic [N_DEST-1:0] STB,
  input  logic [N_DEST-1:0] ACK,
  input  logic [SEL_W-1:0]  RD_SEL,
  output logic [WIDTH-1:0]  RD_Y
);
  state_t state, state_nx;
  logic [SEL_W-1:0] sel_q;
  logic [N_DEST-1:0] sel_dec, stb_q;
  logic [WIDTH-1:0] y_q [N_DEST];
  logic accept, ack_hit;
  dec3to8 u_dec (.sel(SEL), .onehot(sel_dec));
  assign accept = (state == ST_IDLE) && VALID;
`ifdef DEMUX8_WR_AUTOACK_EN
  logic unused_ack;
  assign unused_ack = ^{ACK, sel_q};
  assign ack_hit = 1'b1;
`else
  assign ack_hit = ACK[sel_q];
`endif
  always_comb begin
    state_nx = (state == ST_IDLE) ? (VALID ? ST_PEND : ST_IDLE) : (ack_hit ? ST_IDLE : ST_PEND);
  end
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      sel_q <= '0;
      stb_q <= '0;
      for (int i = 0; i < N_DEST; i++) y_q[i] <= '0;
    end else if (accept) begin
      sel_q <= SEL;
      stb_q <= sel_dec;
      for (int i = 0; i < N_DEST; i++) if (sel_dec[i]) y_q[i] <= D;
    end else if (state == ST_PEND && ack_hit) begin
      stb_q <= '0;
    end
  end
  assign READY = state == ST_IDLE;
  assign STB = stb_q;
  assign RD_Y = y_q[RD_SEL];
  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign Y4 = y_q[4];
  assign Y5 = y_q[5];
  assign Y6 = y_q[6];
  assign Y7 = y_q[7];
endmodule
